// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scheduler.
package disp_pkg;

  // Display mode: plain scan, or one digit pair blinking while being adjusted.
  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StBlinkMin = 2'd1,
    StBlinkSec = 2'd2
  } disp_state_e;

  // Active-low cathodes, so all-ones turns every segment off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int unsigned SCAN_DIV_DEFAULT  = 100000;
  localparam int unsigned BLINK_DIV_DEFAULT = 25000000;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every Div cycles, restartable by a synchronous clear.
module tick_gen #(
  parameter int unsigned Div = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // A clear suppresses the tick so a restarted period is always a full one.
  assign tick_o = ~clr_i && (cnt_q == CntW'(Div - 1));

  // Count up, wrap on tick, restart on clear.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Scans four active-low digits onto a shared cathode bus and blanks the pair being adjusted.
module display_scheduler
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = SCAN_DIV_DEFAULT,
  parameter int unsigned BLINK_DIV = BLINK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adj,
  input  logic       sel,
  input  logic [7:0] dig3,
  input  logic [7:0] dig2,
  input  logic [7:0] dig1,
  input  logic [7:0] dig0,
  output logic [3:0] an,
  output logic [7:0] seg
);

  disp_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        phase_q, phase_d;   // 1 = selected pair hidden
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic        scan_tick, blink_tick, blink_clr;
  logic [7:0]  dig_sel;
  logic        hide;

  // Blink timing restarts on every mode change and is parked while running.
  assign blink_clr = (state_d != state_q) || (state_q == StRun);

  tick_gen #(.Div(SCAN_DIV)) u_scan_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (1'b0),
    .tick_o (scan_tick)
  );

  tick_gen #(.Div(BLINK_DIV)) u_blink_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (blink_clr),
    .tick_o (blink_tick)
  );

  // Mode decode, scan index advance and blink phase update.
  always_comb begin
    state_d = StRun;
    if (adj) begin
      state_d = sel ? StBlinkSec : StBlinkMin;
    end
    idx_d   = scan_tick ? idx_q + 2'd1 : idx_q;
    phase_d = phase_q;
    if (blink_clr) begin
      phase_d = 1'b0;
    end else if (blink_tick) begin
      phase_d = ~phase_q;
    end
  end

  // Output pattern for the digit currently being scanned.
  always_comb begin
    dig_sel = dig0;
    unique case (idx_q)
      2'd0: dig_sel = dig0;
      2'd1: dig_sel = dig1;
      2'd2: dig_sel = dig2;
      2'd3: dig_sel = dig3;
      default: dig_sel = dig0;
    endcase
    // Digits 3/2 are minutes, 1/0 seconds; only the adjusted pair may blank.
    hide  = phase_q && (((state_q == StBlinkMin) && idx_q[1]) ||
                        ((state_q == StBlinkSec) && !idx_q[1]));
    an_d  = ~(4'b0001 << idx_q);
    seg_d = hide ? SEG_BLANK : dig_sel;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      idx_q   <= 2'd0;
      phase_q <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have a parameter SCAN_DIV, default 100000, giving clk cycles per digit scan step (minimum 1).
REQ-002 The block SHALL have a parameter BLINK_DIV, default 25000000, giving clk cycles per blink half-period (minimum 1).
REQ-003 clk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 adj  input  1  level; 1 = adjust mode (blinking enabled), 0 = run mode.
REQ-006 sel  input  1  in adjust mode: 0 = minutes pair blinks, 1 = seconds pair blinks.
REQ-007 dig3, dig2, dig1, dig0  input  8 each  active-low segment patterns; dig3/dig2 = minutes tens/units, dig1/dig0 = seconds tens/units; dig3 is leftmost.
REQ-008 an  output  4  active-low anode select; bit n enables digit n.
REQ-009 seg  output  8  active-low cathode pattern for the enabled digit; 8'hFF = blank.

Function
REQ-010 A scan prescaler SHALL assert a one-cycle scan tick every SCAN_DIV cycles; on each tick the scan index idx SHALL advance 0->1->2->3->0.
REQ-011 an and seg SHALL be registered and SHALL reflect idx, the current inputs and blink state with exactly one clk of latency; an SHALL equal ~(1<<idx).
REQ-012 The FSM SHALL have states RUN, BLINK_MIN and BLINK_SEC, registered each cycle: adj=0 -> RUN; adj=1 and sel=0 -> BLINK_MIN; adj=1 and sel=1 -> BLINK_SEC.
REQ-013 In RUN, seg SHALL equal dig[idx] and the blink counter and phase SHALL be held at 0.
REQ-014 In a blink state, the blink counter SHALL toggle the phase every BLINK_DIV cycles; phase 0 = visible, phase 1 = hidden.
REQ-015 While hidden, selected-pair digits (3,2 for BLINK_MIN; 1,0 for BLINK_SEC) SHALL output seg=8'hFF with an still driven; unselected digits SHALL never be blanked.
REQ-016 Any state change SHALL clear the blink counter and force phase to visible in the same cycle, so each blink state begins with a full visible half-period.
REQ-017 A scan tick and a blink toggle in the same cycle SHALL both take effect independently.
REQ-018 Input digit changes SHALL appear on seg one cycle later if that digit is selected; no input latching beyond this SHALL occur.
REQ-019 With SCAN_DIV=1 idx SHALL advance every cycle; with BLINK_DIV=1 phase SHALL toggle every cycle.

Reset
REQ-020 While rst_n=0: an=4'b1111, seg=8'hFF, idx=0, state=RUN, both counters=0, phase=visible, all applied asynchronously.
REQ-021 On the first rising edge after rst_n rises: an=4'b1110, seg=dig0.
REQ-022 Reset asserted mid-scan or mid-blink SHALL abort immediately with no residual state.

Structure
REQ-023 A shared package disp_pkg SHALL hold the state enumeration, the constant SEG_BLANK=8'hFF and the default SCAN_DIV/BLINK_DIV values.
REQ-024 A sub-module tick_gen (parameterised divider, synchronous clear input, one-cycle tick output) SHALL be instantiated twice: once for scan, once for blink (with clear).

Verification (SCAN_DIV=4, BLINK_DIV=8)
REQ-025 rst_n pulsed low mid-scan -> an=1111 and seg=FF without waiting for clk; after release, an=1110 and seg=dig0 on the first edge.
REQ-026 RUN, dig0..dig3 = C0,F9,A4,B0 -> an steps 1110,1101,1011,0111 for 4 cycles each with seg C0,F9,A4,B0, then wraps to 1110.
REQ-027 adj=1, sel=0 -> cycles 0-7 after entry all digits visible, cycles 8-15 digits 3/2 give seg=FF, pattern repeats; digits 1/0 are never FF.
REQ-028 sel 0->1 during the hidden phase -> next cycle minutes visible, phase visible; seconds digits first blank 8 cycles later.
REQ-029 adj 1->0 during the hidden phase -> from the next cycle all digits visible and the blink counter holds 0.
REQ-030 SCAN_DIV=1 -> an rotates every cycle; a scan tick and a blink toggle coincide -> the new idx and new phase are both visible together on the following cycle.
